// File: rtl/bram_dp_if.sv
// rtl/bram_dp_if.sv - request/response bundle for the dual-port BRAM
// Purpose: groups both port request/response signals and the clear handshake.
// Signals:
//   en0/we0/a0/di0 -> port 0 request (enable, byte write enables, word address, write data)
//   do0/vld0       <- port 0 read data and read-valid pulse
//   en1/we1/a1/di1/do1/vld1  same set for port 1
//   clr -> start zero-fill of the array; busy <- clear engine active
// Modports: master drives requests, slave is the RAM.
interface bram_dp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   localparam int NB = DATA_W / 8;

   logic              en0;
   logic [NB-1:0]     we0;
   logic [ADDR_W-1:0] a0;
   logic [DATA_W-1:0] di0;
   logic [DATA_W-1:0] do0;
   logic              vld0;

   logic              en1;
   logic [NB-1:0]     we1;
   logic [ADDR_W-1:0] a1;
   logic [DATA_W-1:0] di1;
   logic [DATA_W-1:0] do1;
   logic              vld1;

   logic              clr;
   logic              busy;

   modport master (
      output en0, we0, a0, di0, en1, we1, a1, di1, clr,
      input  do0, vld0, do1, vld1, busy
   );

   modport slave (
      input  en0, we0, a0, di0, en1, we1, a1, di1, clr,
      output do0, vld0, do1, vld1, busy
   );
endinterface

// File: rtl/bram_dp.sv
// rtl/bram_dp.sv - true dual-port byte-write BRAM with read-valid strobes and clear engine
// Purpose: two independent read-first ports on one array, optional output register,
//          and a hardware engine that zero-fills the array after a clear request.
// Ports:
//   clk   - single clock, all logic on posedge
//   rst_n - asynchronous active-low reset (array contents are not reset)
//   bus   - bram_dp_if slave: per-port en/we/a/di requests, do/vld responses, clr/busy
module bram_dp #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int OUT_REG = 0
) (
   input  logic     clk,
   input  logic     rst_n,
   bram_dp_if.slave bus
);
   localparam int                NB    = DATA_W / 8;
   localparam int                DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   LAST  = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   ONE   = (ADDR_W + 1)'(1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   cnt, cnt_nxt;
   logic              busy;
   logic              acc0, acc1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd0, rd1;
   logic              rv0, rv1;

   assign busy     = (state == CLEAR);
   assign bus.busy = busy;
   // Requests are dropped entirely while the clear engine owns the array.
   assign acc0     = bus.en0 & ~busy;
   assign acc1     = bus.en1 & ~busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.clr) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            cnt_nxt = cnt + ONE;
            if (cnt == LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Port 1 lanes are scheduled first so port 0 overrides them on a same-address collision.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[cnt[ADDR_W-1:0]] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (acc1 && bus.we1[i]) mem[bus.a1][8*i +: 8] <= bus.di1[8*i +: 8];
         end
         for (int i = 0; i < NB; i++) begin
            if (acc0 && bus.we0[i]) mem[bus.a0][8*i +: 8] <= bus.di0[8*i +: 8];
         end
      end
   end

   // Read-first: the array read samples the pre-write word. Idle cycles push zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd0 <= '0;
         rd1 <= '0;
         rv0 <= 1'b0;
         rv1 <= 1'b0;
      end else begin
         rd0 <= acc0 ? mem[bus.a0] : '0;
         rd1 <= acc1 ? mem[bus.a1] : '0;
         rv0 <= acc0;
         rv1 <= acc1;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] od0, od1;
         logic              ov0, ov1;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               od0 <= '0;
               od1 <= '0;
               ov0 <= 1'b0;
               ov1 <= 1'b0;
            end else begin
               od0 <= rd0;
               od1 <= rd1;
               ov0 <= rv0;
               ov1 <= rv1;
            end
         end
         assign bus.do0  = od0;
         assign bus.do1  = od1;
         assign bus.vld0 = ov0;
         assign bus.vld1 = ov1;
      end else begin : g_no_out_reg
         assign bus.do0  = rd0;
         assign bus.do1  = rd1;
         assign bus.vld0 = rv0;
         assign bus.vld1 = rv1;
      end
   endgenerate
endmodule

// File: tb/tb_bram_dp.sv
// tb/tb_bram_dp.sv - scoreboard bench for bram_dp (OUT_REG=0 and OUT_REG=1 side by side)
module tb_bram_dp;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] data;
      int          issue;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   bram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   bram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   bram_dp #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   bram_dp #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic [31:0] model [DEPTH];
   int          clr_left = 0;
   exp_t        q0[$], q1[$], q2[$], q3[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   task automatic mon(input int id, input logic v, input logic [31:0] d, input int lat);
      exp_t e;
      bit   got;
      string nm;
      nm = $sformatf("out%0d", id);
      got = 0;
      if (!v) begin
         chk({nm, "_idle_zero"}, d, 32'h0);
      end else begin
         case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); got = 1; end
         endcase
         if (!got) begin
            chk({nm, "_spurious_vld"}, 32'h1, 32'h0);
         end else begin
            chk({nm, "_data"}, d, e.data);
            chk({nm, "_latency"}, 32'(cyc - e.issue), 32'(lat));
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, bus0.vld0, bus0.do0, 1);
      mon(1, bus0.vld1, bus0.do1, 1);
      mon(2, bus1.vld0, bus1.do0, 2);
      mon(3, bus1.vld1, bus1.do1, 2);
   end

   // One clock of stimulus; the model decides what the RAM must do with it.
   task automatic step(input logic e0, input logic [3:0] w0, input logic [3:0] ad0,
                       input logic [31:0] d0, input logic e1, input logic [3:0] w1,
                       input logic [3:0] ad1, input logic [31:0] d1, input logic c);
      exp_t x;
      @(negedge clk);
      chk("busy_r0", {31'b0, bus0.busy}, {31'b0, clr_left > 0});
      chk("busy_r1", {31'b0, bus1.busy}, {31'b0, clr_left > 0});
      bus0.en0 = e0; bus0.we0 = w0; bus0.a0 = ad0; bus0.di0 = d0;
      bus0.en1 = e1; bus0.we1 = w1; bus0.a1 = ad1; bus0.di1 = d1; bus0.clr = c;
      bus1.en0 = e0; bus1.we0 = w0; bus1.a0 = ad0; bus1.di0 = d0;
      bus1.en1 = e1; bus1.we1 = w1; bus1.a1 = ad1; bus1.di1 = d1; bus1.clr = c;
      if (clr_left > 0) begin
         model[DEPTH - clr_left] = 32'h0;
         clr_left--;
      end else begin
         x.issue = cyc;
         if (e0) begin x.data = model[ad0]; q0.push_back(x); q2.push_back(x); end
         if (e1) begin x.data = model[ad1]; q1.push_back(x); q3.push_back(x); end
         if (e1) model[ad1] = merge(model[ad1], d1, w1);
         if (e0) model[ad0] = merge(model[ad0], d0, w0);
         if (c) clr_left = DEPTH;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy0"}, {31'b0, bus0.busy}, 32'h0);
      chk({tag, "_busy1"}, {31'b0, bus1.busy}, 32'h0);
      chk({tag, "_vld"}, {28'b0, bus0.vld0, bus0.vld1, bus1.vld0, bus1.vld1}, 32'h0);
      chk({tag, "_do0_r0"}, bus0.do0, 32'h0);
      chk({tag, "_do1_r0"}, bus0.do1, 32'h0);
      chk({tag, "_do0_r1"}, bus1.do0, 32'h0);
      chk({tag, "_do1_r1"}, bus1.do1, 32'h0);
   endtask

   initial begin
      bus0.en0 = 0; bus0.we0 = 0; bus0.a0 = 0; bus0.di0 = 0;
      bus0.en1 = 0; bus0.we1 = 0; bus0.a1 = 0; bus0.di1 = 0; bus0.clr = 0;
      bus1.en0 = 0; bus1.we0 = 0; bus1.a0 = 0; bus1.di0 = 0;
      bus1.en1 = 0; bus1.we1 = 0; bus1.a1 = 0; bus1.di1 = 0; bus1.clr = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;

      // Zero-fill through the clear engine so every word has a known value.
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(DEPTH + 1);

      // Write then read back, both latencies.
      step(1, 4'hF, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      step(1, 4'h0, 5, 0, 0, 0, 0, 0, 0);
      idle(3);

      // Byte lanes with read-first.
      step(1, 4'hF, 7, 32'h11223344, 0, 0, 0, 0, 0);
      step(1, 4'b0101, 7, 32'hAABBCCDD, 0, 0, 0, 0, 0);
      step(1, 4'h0, 7, 0, 0, 0, 0, 0, 0);
      idle(3);

      // Both ports write the same address in the same cycle.
      step(1, 4'b0011, 3, 32'h0000AAAA, 1, 4'b1111, 3, 32'h55555555, 0);
      step(1, 4'h0, 3, 0, 1, 4'h0, 3, 0, 0);
      idle(3);

      // Port 1 writes while port 0 reads the same address.
      step(1, 4'hF, 9, 32'h1, 0, 0, 0, 0, 0);
      step(1, 4'h0, 9, 0, 1, 4'hF, 9, 32'h2, 0);
      step(1, 4'h0, 9, 0, 0, 0, 0, 0, 0);
      idle(3);

      // Randomised traffic, with occasional clear pulses.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(3, 0) != 0, 4'($urandom), 4'($urandom), $urandom,
              $urandom_range(3, 0) != 0, 4'($urandom), 4'($urandom), $urandom,
              $urandom_range(59, 0) == 0);
      end
      idle(DEPTH + 3);

      // Full clear: fill with ones, clear, requests during busy are dropped.
      for (int i = 0; i < DEPTH; i++) step(1, 4'hF, 4'(i), 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) step(1, 4'hF, 4'(i), 32'h12345678, 1, 0, 4'(i), 0, 1);
      for (int i = 0; i < DEPTH; i++) step(1, 0, 4'(i), 0, 1, 0, 4'(15 - i), 0, 0);
      idle(3);

      // Reset in the middle of a clear.
      for (int i = 0; i < DEPTH; i++) step(1, 4'hF, 4'(i), 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(6);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("async_reset");
      clr_left = 0;
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) step(1, 0, 4'(i), 0, 1, 0, 4'(15 - i), 0, 0);
      step(1, 0, 5, 0, 1, 0, 15, 0, 0);
      chk("model_word5", model[5], 32'h0);
      chk("model_word15", model[15], 32'hFFFFFFFF);
      idle(4);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      chk("q3_drained", q3.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
